// File: rtl/syscall_pkg.sv
// syscall_pkg
// Shared definitions for the SYSCALL sequencer slice:
//   state_t            - FSM state encoding (RUN/PRINT/PAUSE/HALT)
//   ST_RUN .. ST_HALT  - state constants
//   SYS_EXIT/SYS_PRINT - default $v0 service codes
package syscall_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_PRINT = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  localparam logic [31:0] SYS_EXIT  = 32'd10;
  localparam logic [31:0] SYS_PRINT = 32'd34;

endpackage

// File: rtl/go_edge_sync.sv
// go_edge_sync
// Brings a raw board push-button into the CLK domain and turns each rising
// edge into a single-cycle pulse.
// Ports:
//   CLK    in   system clock, rising edge
//   CLR_N  in   asynchronous active-low reset
//   btn    in   raw button level, asynchronous to CLK
//   press  out  one-cycle pulse per synchronized rising edge
// All flops clear to 0, so a button already held high when reset releases
// is seen as one press.
module go_edge_sync (
  input  logic CLK,
  input  logic CLR_N,
  input  logic btn,
  output logic press
);

  logic btn_p0;
  logic btn_p1;
  logic btn_p2;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      btn_p2 <= 1'b0;
    end else begin
      // stage 0/1: two-flop synchronizer
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      // stage 2: previous synchronized level for edge detection
      btn_p2 <= btn_p1;
    end
  end

  assign press = btn_p1 & ~btn_p2;

endmodule

// File: rtl/syscall_sequencer.sv
// syscall_sequencer
// Sequences SYSCALL instructions for the pipelined MIPS CPU: decodes the
// service code in $v0, freezes the pipeline while a service is in progress,
// hands $a0 to the board display over valid/ready, and holds the CPU halted
// until GO releases it.
// Ports:
//   CLK        in   system clock, rising edge
//   CLR_N      in   asynchronous active-low reset
//   SYSCALL    in   decoded SYSCALL in the stage that reads v0/a0
//   v0, a0     in   forwarded $v0 / $a0
//   GO         in   raw push-button
//   disp_ready in   display accepts the word
//   display    out  last printed value
//   disp_valid out  display holds a word not yet accepted
//   stall      out  freeze PC and pipeline registers
//   halt       out  CPU halted by an exit syscall
//   sys_cnt    out  accepted syscall count, saturating
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter logic [31:0] CODE_EXIT   = SYS_EXIT,
  parameter logic [31:0] CODE_PRINT  = SYS_PRINT,
  parameter bit          PRINT_PAUSE = 1'b0,
  parameter int          CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             SYSCALL,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  input  logic             GO,
  input  logic             disp_ready,
  output logic [31:0]      display,
  output logic             disp_valid,
  output logic             stall,
  output logic             halt,
  output logic [CNT_W-1:0] sys_cnt
);

  state_t state;
  logic   go_press;
  logic   is_exit;
  logic   is_print;

  go_edge_sync u_go_sync (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .btn   (GO),
    .press (go_press)
  );

  assign is_exit  = (v0 == CODE_EXIT);
  assign is_print = (v0 == CODE_PRINT);

  // The combinational term freezes the pipeline in the very cycle the syscall
  // is decoded, before the FSM has left RUN. No-op codes never stall.
  assign stall = (state != ST_RUN) | (SYSCALL & (is_exit | is_print));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state      <= ST_RUN;
      display    <= '0;
      disp_valid <= 1'b0;
      halt       <= 1'b0;
      sys_cnt    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          // GO presses here are simply dropped; only RUN accepts syscalls.
          if (SYSCALL) begin
            if (sys_cnt != {CNT_W{1'b1}}) begin
              sys_cnt <= sys_cnt + 1'b1;
            end
            if (is_exit) begin
              halt  <= 1'b1;
              state <= ST_HALT;
            end else if (is_print) begin
              display    <= a0;
              disp_valid <= 1'b1;
              state      <= ST_PRINT;
            end
          end
        end
        ST_PRINT: begin
          // display stays untouched until the next print.
          if (disp_valid && disp_ready) begin
            disp_valid <= 1'b0;
            state      <= PRINT_PAUSE ? ST_PAUSE : ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (go_press) begin
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          // The PC already moved past the syscall, so resuming is just RUN.
          if (go_press) begin
            halt  <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_sequencer.sv
`timescale 1ns/1ps
module tb_syscall_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;

  // instance A: default parameters
  logic        sc_a, go_a, rdy_a;
  logic [31:0] v0_a, a0_a;
  logic [31:0] disp_a;
  logic        dv_a, stall_a, halt_a;
  logic [15:0] cnt_a;

  // instance B: PRINT_PAUSE=1, CNT_W=2
  logic        sc_b, go_b, rdy_b;
  logic [31:0] v0_b, a0_b;
  logic [31:0] disp_b;
  logic        dv_b, stall_b, halt_b;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] e;

  syscall_sequencer dut_a (
    .CLK(clk), .CLR_N(clr_n), .SYSCALL(sc_a), .v0(v0_a), .a0(a0_a),
    .GO(go_a), .disp_ready(rdy_a), .display(disp_a), .disp_valid(dv_a),
    .stall(stall_a), .halt(halt_a), .sys_cnt(cnt_a)
  );

  syscall_sequencer #(.PRINT_PAUSE(1'b1), .CNT_W(2)) dut_b (
    .CLK(clk), .CLR_N(clr_n), .SYSCALL(sc_b), .v0(v0_b), .a0(a0_b),
    .GO(go_b), .disp_ready(rdy_b), .display(disp_b), .disp_valid(dv_b),
    .stall(stall_b), .halt(halt_b), .sys_cnt(cnt_b)
  );

  task test_reset;
    clr_n = 1'b0;
    sc_a = 0; go_a = 0; rdy_a = 0; v0_a = 0; a0_a = 0;
    sc_b = 0; go_b = 0; rdy_b = 0; v0_b = 0; a0_b = 0;
    repeat (2) @(negedge clk);
    total++; if (disp_a !== 32'h0) begin bad++; $display("FAIL reset_display got=%h want=0", disp_a); end
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL reset_disp_valid got=%b want=0", dv_a); end
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_a); end
    total++; if (halt_a !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b want=0", halt_a); end
    total++; if (cnt_a !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt_a); end
    total++; if (stall_b !== 1'b0) begin bad++; $display("FAIL reset_stall_b got=%b want=0", stall_b); end
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task test_print;
    sc_a = 1; v0_a = 32'd34; a0_a = 32'hDEADBEEF; rdy_a = 1;
    exp_a.push_back(a0_a);
    #1;
    total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL print_stall_same got=%b want=1", stall_a); end
    @(negedge clk);
    sc_a = 0; v0_a = 0; a0_a = 0;
    e = exp_a.pop_front();
    total++; if (dv_a !== 1'b1) begin bad++; $display("FAIL print_valid got=%b want=1", dv_a); end
    total++; if (disp_a !== e) begin bad++; $display("FAIL print_display got=%h want=%h", disp_a, e); end
    total++; if (cnt_a !== 16'd1) begin bad++; $display("FAIL print_cnt got=%0d want=1", cnt_a); end
    @(negedge clk);
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL print_stall_drop got=%b want=0", stall_a); end
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL print_valid_clear got=%b want=0", dv_a); end
    total++; if (disp_a !== e) begin bad++; $display("FAIL print_display_hold got=%h want=%h", disp_a, e); end
  endtask

  task test_print_backpressure;
    sc_a = 1; v0_a = 32'd34; a0_a = 32'h12345678; rdy_a = 0;
    exp_a.push_back(a0_a);
    @(negedge clk);
    sc_a = 0; v0_a = 0; a0_a = 32'hFFFF0000;
    for (int i = 0; i < 5; i++) begin
      total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL bp_stall[%0d] got=%b want=1", i, stall_a); end
      total++; if (dv_a !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", i, dv_a); end
      total++; if (disp_a !== exp_a[0]) begin bad++; $display("FAIL bp_display[%0d] got=%h want=%h", i, disp_a, exp_a[0]); end
      @(negedge clk);
    end
    rdy_a = 1;
    @(negedge clk);
    e = exp_a.pop_front();
    total++; if (dv_a !== 1'b0) begin bad++; $display("FAIL bp_accept_valid got=%b want=0", dv_a); end
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL bp_accept_stall got=%b want=0", stall_a); end
    total++; if (disp_a !== e) begin bad++; $display("FAIL bp_accept_display got=%h want=%h", disp_a, e); end
    total++; if (cnt_a !== 16'd2) begin bad++; $display("FAIL bp_cnt got=%0d want=2", cnt_a); end
  endtask

  task test_exit;
    int n;
    // GO pressed and released while running: must be forgotten
    go_a = 1; repeat (4) @(negedge clk);
    go_a = 0; repeat (4) @(negedge clk);
    total++; if (halt_a !== 1'b0 || stall_a !== 1'b0) begin bad++; $display("FAIL go_in_run got=%b%b want=00", halt_a, stall_a); end
    sc_a = 1; v0_a = 32'd10;
    #1;
    total++; if (stall_a !== 1'b1) begin bad++; $display("FAIL exit_stall_same got=%b want=1", stall_a); end
    @(negedge clk);
    sc_a = 0; v0_a = 0;
    total++; if (halt_a !== 1'b1) begin bad++; $display("FAIL exit_halt got=%b want=1", halt_a); end
    total++; if (cnt_a !== 16'd3) begin bad++; $display("FAIL exit_cnt got=%0d want=3", cnt_a); end
    repeat (5) @(negedge clk);
    total++; if (halt_a !== 1'b1 || stall_a !== 1'b1) begin bad++; $display("FAIL exit_hold got=%b%b want=11", halt_a, stall_a); end
    go_a = 1;
    n = 0;
    while (halt_a === 1'b1 && n < 8) begin @(negedge clk); n++; end
    total++; if (halt_a !== 1'b0 || n < 3 || n > 4) begin bad++; $display("FAIL exit_go_release halt=%b cycles=%0d want halt=0 in 3..4", halt_a, n); end
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL exit_stall_release got=%b want=0", stall_a); end
    go_a = 0;
    repeat (3) @(negedge clk);
  endtask

  task test_noop;
    sc_a = 1; v0_a = 32'd5; a0_a = 32'hCAFEF00D;
    #1;
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL noop_stall got=%b want=0", stall_a); end
    @(negedge clk);
    sc_a = 0; v0_a = 0; a0_a = 0;
    total++; if (halt_a !== 1'b0) begin bad++; $display("FAIL noop_halt got=%b want=0", halt_a); end
    total++; if (disp_a !== 32'h12345678) begin bad++; $display("FAIL noop_display got=%h want=12345678", disp_a); end
    total++; if (cnt_a !== 16'd4) begin bad++; $display("FAIL noop_cnt got=%0d want=4", cnt_a); end
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL noop_stall_after got=%b want=0", stall_a); end
  endtask

  task test_pause;
    int n;
    sc_b = 1; v0_b = 32'd34; a0_b = 32'hA5A5_5A5A; rdy_b = 1;
    exp_b.push_back(a0_b);
    @(negedge clk);
    sc_b = 0; v0_b = 0; a0_b = 0;
    e = exp_b.pop_front();
    total++; if (dv_b !== 1'b1 || disp_b !== e) begin bad++; $display("FAIL pause_print got=%b/%h want=1/%h", dv_b, disp_b, e); end
    @(negedge clk);
    total++; if (dv_b !== 1'b0) begin bad++; $display("FAIL pause_valid_clear got=%b want=0", dv_b); end
    repeat (4) @(negedge clk);
    total++; if (stall_b !== 1'b1) begin bad++; $display("FAIL pause_hold got=%b want=1", stall_b); end
    go_b = 1;
    n = 0;
    while (stall_b === 1'b1 && n < 8) begin @(negedge clk); n++; end
    total++; if (stall_b !== 1'b0 || n > 4) begin bad++; $display("FAIL pause_go_release stall=%b cycles=%0d want 0 within 4", stall_b, n); end
    total++; if (cnt_b !== 2'd1) begin bad++; $display("FAIL pause_cnt got=%0d want=1", cnt_b); end
    go_b = 0;
    repeat (3) @(negedge clk);
  endtask

  task test_reset_mid_print;
    sc_a = 1; v0_a = 32'd34; a0_a = 32'h0BADF00D; rdy_a = 0;
    exp_a.push_back(a0_a);
    @(negedge clk);
    sc_a = 0; v0_a = 0; a0_a = 0;
    total++; if (dv_a !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b want=1", dv_a); end
    #2 clr_n = 1'b0;
    #1;
    exp_a.delete();
    total++; if (dv_a !== 1'b0 || stall_a !== 1'b0 || halt_a !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got=%b%b%b want=000", dv_a, stall_a, halt_a); end
    total++; if (disp_a !== 32'h0 || cnt_a !== 16'h0) begin bad++; $display("FAIL midrst_data got=%h/%0d want=0/0", disp_a, cnt_a); end
    @(negedge clk);
    clr_n = 1'b1;
    rdy_a = 1;
    @(negedge clk);
    sc_a = 1; v0_a = 32'd34; a0_a = 32'h00C0FFEE;
    exp_a.push_back(a0_a);
    @(negedge clk);
    sc_a = 0; v0_a = 0; a0_a = 0;
    e = exp_a.pop_front();
    total++; if (disp_a !== e || dv_a !== 1'b1) begin bad++; $display("FAIL midrst_reprint got=%h/%b want=%h/1", disp_a, dv_a, e); end
    @(negedge clk);
    total++; if (stall_a !== 1'b0) begin bad++; $display("FAIL midrst_run got=%b want=0", stall_a); end
  endtask

  task test_back_to_back_saturate;
    sc_b = 1; v0_b = 32'd5;
    repeat (3) @(negedge clk);
    total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_three got=%0d want=3", cnt_b); end
    @(negedge clk);
    sc_b = 0; v0_b = 0;
    total++; if (cnt_b !== 2'd3) begin bad++; $display("FAIL sat_four got=%0d want=3", cnt_b); end
    total++; if (stall_b !== 1'b0) begin bad++; $display("FAIL sat_stall got=%b want=0", stall_b); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_print_backpressure();
    test_exit();
    test_noop();
    test_pause();
    test_reset_mid_print();
    test_back_to_back_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syscall_sequencer.md
# syscall_sequencer

Synchronous controller that sequences SYSCALL instructions for the pipelined MIPS CPU. It decodes the service code in `v0`, freezes the pipeline while a service is in progress, hands `a0` to the board display through a valid/ready handshake, and holds the CPU halted until the GO button releases it. It sits beside the register file / WB stage and drives the global stall and halt lines.

## Interface
- `CODE_EXIT`, default 10: `v0` value that halts the CPU.
- `CODE_PRINT`, default 34: `v0` value that prints `a0` in hex.
- `PRINT_PAUSE`, default 0: 1 = after a print completes, pause until GO.
- `CNT_W`, default 16: width of the syscall counter.
- `CLK`  in  1  system clock, rising edge.
- `CLR_N`  in  1  asynchronous, active-low reset.
- `SYSCALL`  in  1  decoded SYSCALL, valid in the stage where `v0`/`a0` are read.
- `v0`  in  32  forwarded `$v0` value.
- `a0`  in  32  forwarded `$a0` value.
- `GO`  in  1  raw push-button, asynchronous to `CLK`.
- `disp_ready`  in  1  display accepts the word.
- `display`  out  32  last printed value.
- `disp_valid`  out  1  `display` holds a word not yet accepted.
- `stall`  out  1  freeze PC and all pipeline registers.
- `halt`  out  1  CPU halted by an exit syscall.
- `sys_cnt`  out  `CNT_W`  number of accepted syscalls, saturating.

## Operation
- States: RUN, PRINT, PAUSE, HALT. Reset state: RUN.
- All outputs reset to 0.
- RUN, `SYSCALL`=1:
  - `v0`==`CODE_EXIT`: go to HALT.
  - `v0`==`CODE_PRINT`: load `display`<=`a0`, set `disp_valid`, go to PRINT.
  - Any other code: no-op; stay in RUN.
  - `sys_cnt` increments for every accepted SYSCALL, including no-ops, and saturates at all-ones.
- PRINT: hold until `disp_ready`=1 while `disp_valid`=1. On that cycle clear `disp_valid`, then go to PAUSE if `PRINT_PAUSE`=1, else RUN.
- PAUSE: go to RUN on a GO press.
- HALT: `halt`=1. On a GO press, clear `halt` and go to RUN; the PC has already advanced past the syscall.
- GO press: rising edge of `GO` after a 2-flop synchronizer. Presses in RUN or PRINT are discarded and not remembered.
- `SYSCALL` in any state other than RUN is ignored; it cannot occur while the pipeline is frozen.
- `display` keeps its value after the handshake until the next print.

## Timing
- `stall` = (state != RUN) | (`SYSCALL` & (`v0`==`CODE_EXIT` | `v0`==`CODE_PRINT`)).
  - The combinational term freezes the pipeline in the same cycle as the syscall.
  - The rest of `stall` is registered state.
- `stall` is not asserted for no-op codes.
- `display`, `disp_valid`, `halt` and `sys_cnt` are registered and update at the edge that samples `SYSCALL`.
- Print latency: `disp_valid` high 1 cycle after SYSCALL. With `disp_ready` already high, `stall` drops 2 cycles after SYSCALL.
- GO latency: 2 sync cycles + 1 edge-detect cycle, so `halt`/`stall` clear 3–4 cycles after the `GO` rising edge.
- Handshake: once `disp_valid` rises, `display` stays stable until accepted. `disp_ready` while `disp_valid`=0 has no effect.
- `CLR_N` low at any time returns to RUN with all outputs 0. This includes mid-print: `disp_valid` drops and the word is lost.
- The synchronizer flops are reset to 0, so a held-high `GO` after reset counts as one press.

## Structure
- Shared package `syscall_pkg`:
  - state encoding typedef (RUN/PRINT/PAUSE/HALT);
  - default service codes `SYS_EXIT`=10 and `SYS_PRINT`=34.
- Sub-module `go_edge_sync`: 2-flop synchronizer plus rising-edge one-cycle pulse. It has its own `CLK`/`CLR_N` and is reused for other board buttons.
- The FSM, display register and counter live in `syscall_sequencer`.

## Test plan
- Reset, then SYSCALL with `v0`=34, `a0`=0xDEADBEEF, `disp_ready`=1:
  - `stall`=1 in the syscall cycle;
  - `display`=0xDEADBEEF and `disp_valid`=1 next cycle;
  - `stall`=0 the cycle after;
  - `sys_cnt`=1.
- Print with `disp_ready` held low for 5 cycles: `display` stable, `stall`=1 throughout, completion on the cycle `disp_ready` rises.
- SYSCALL with `v0`=10:
  - `halt`=1 and `stall`=1;
  - GO pulses while in RUN beforehand have no effect;
  - a GO press clears `halt` within 4 cycles.
- SYSCALL with `v0`=5: no `stall`, `halt` and `display` unchanged, `sys_cnt` increments.
- `PRINT_PAUSE`=1: print completes, then the block stays stalled until GO, then returns to RUN.
- Assert `CLR_N` low mid-PRINT: all outputs 0 immediately (async), then RUN. With `CNT_W`=2, four syscalls leave `sys_cnt`=3.
